// File: rtl/add_sub_result_stage_if.sv
// Handshake and status bundle between the adder/subtractor, the result stage and its consumer.
// The slave modport is the result stage's view of the bundle.
interface add_sub_result_stage_if #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_sum;
    logic                 in_overflow;
    logic                 in_sub;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_result;
    logic                 out_zero;
    logic                 out_negative;
    logic                 out_overflow;
    logic                 out_sub;
    logic [1:0]           level;
    logic                 clear_status;
    logic                 sticky_overflow;
    logic [CNT_WIDTH-1:0] overflow_count;

    modport slave (
        input  in_valid, in_sum, in_overflow, in_sub, out_ready, clear_status,
        output in_ready, out_valid, out_result, out_zero, out_negative,
               out_overflow, out_sub, level, sticky_overflow, overflow_count
    );

    modport master (
        output in_valid, in_sum, in_overflow, in_sub, out_ready, clear_status,
        input  in_ready, out_valid, out_result, out_zero, out_negative,
               out_overflow, out_sub, level, sticky_overflow, overflow_count
    );
endinterface

// File: rtl/add_sub_result_stage.sv
// Registered result stage behind the 16-bit adder/subtractor: two-entry valid/ready queue with
// zero/negative flags, plus a sticky overflow flag and a saturating overflow event counter.
module add_sub_result_stage #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 2,
    parameter int CNT_WIDTH = 8
) (
    input  logic [4:0]             logisimClockTree0,
    input  logic                   reset,
    add_sub_result_stage_if.slave  bus
);
    logic clk;
    logic tick;
    logic unused_clock_bits;

    assign clk  = logisimClockTree0[4];
    assign tick = logisimClockTree0[2];
    assign unused_clock_bits = ^{logisimClockTree0[3], logisimClockTree0[1:0]};

    logic [WIDTH-1:0]     sum_q [2];
    logic [1:0]           zero_q;
    logic [1:0]           neg_q;
    logic [1:0]           ovf_q;
    logic [1:0]           sub_q;
    logic                 wr_ptr_q;
    logic                 rd_ptr_q;
    logic [1:0]           level_q;
    logic [1:0]           level_d;
    logic                 sticky_q;
    logic                 sticky_d;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    logic push;
    logic pop;
    logic push_ovf;

    assign bus.in_ready  = (level_q != 2'(DEPTH));
    assign bus.out_valid = (level_q != 2'd0);

    assign push     = bus.in_valid && bus.in_ready;
    assign pop      = bus.out_valid && bus.out_ready;
    assign push_ovf = push && bus.in_overflow;

    // Head outputs are forced to zero when empty so stale popped entries never show.
    assign bus.out_result   = bus.out_valid ? sum_q[rd_ptr_q] : '0;
    assign bus.out_zero     = bus.out_valid && zero_q[rd_ptr_q];
    assign bus.out_negative = bus.out_valid && neg_q[rd_ptr_q];
    assign bus.out_overflow = bus.out_valid && ovf_q[rd_ptr_q];
    assign bus.out_sub      = bus.out_valid && sub_q[rd_ptr_q];

    assign bus.level           = level_q;
    assign bus.sticky_overflow = sticky_q;
    assign bus.overflow_count  = cnt_q;

    always_comb begin
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + 2'd1;
        end else if (pop && !push) begin
            level_d = level_q - 2'd1;
        end
    end

    // An overflowing push in the same cycle as a clear wins over the clear.
    always_comb begin
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        if (bus.clear_status) begin
            sticky_d = push_ovf;
            cnt_d    = push_ovf ? CNT_WIDTH'(1) : '0;
        end else if (push_ovf) begin
            sticky_d = 1'b1;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (tick) begin
            if (reset) begin
                level_q  <= '0;
                wr_ptr_q <= 1'b0;
                rd_ptr_q <= 1'b0;
                sticky_q <= 1'b0;
                cnt_q    <= '0;
                zero_q   <= '0;
                neg_q    <= '0;
                ovf_q    <= '0;
                sub_q    <= '0;
                for (int unsigned i = 0; i < 2; i++) begin
                    sum_q[i] <= '0;
                end
            end else begin
                level_q  <= level_d;
                sticky_q <= sticky_d;
                cnt_q    <= cnt_d;
                if (push) begin
                    sum_q[wr_ptr_q]  <= bus.in_sum;
                    zero_q[wr_ptr_q] <= (bus.in_sum == '0);
                    neg_q[wr_ptr_q]  <= bus.in_sum[WIDTH-1];
                    ovf_q[wr_ptr_q]  <= bus.in_overflow;
                    sub_q[wr_ptr_q]  <= bus.in_sub;
                    wr_ptr_q         <= ~wr_ptr_q;
                end
                if (pop) begin
                    rd_ptr_q <= ~rd_ptr_q;
                end
            end
        end
    end
endmodule

// File: tb/tb_add_sub_result_stage.sv
// Directed bench for add_sub_result_stage: handshake, ordering, saturation, reset and tick gating.
module tb_add_sub_result_stage;
    logic clk4 = 1'b0;
    logic tick = 1'b1;
    logic reset = 1'b1;
    logic [4:0] tree;
    int checks = 0;
    int errors = 0;

    assign tree = {clk4, 1'b0, tick, 2'b00};

    add_sub_result_stage_if #(.WIDTH(16), .CNT_WIDTH(8)) bus ();

    add_sub_result_stage #(.WIDTH(16), .DEPTH(2), .CNT_WIDTH(8)) dut (
        .logisimClockTree0 (tree),
        .reset             (reset),
        .bus               (bus.slave)
    );

    always #5 clk4 = ~clk4;

    task automatic step();
        @(posedge clk4);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] s, input logic o, input logic sb,
                         input logic ordy);
        bus.in_valid    = v;
        bus.in_sum      = s;
        bus.in_overflow = o;
        bus.in_sub      = sb;
        bus.out_ready   = ordy;
    endtask

    initial begin
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        bus.clear_status = 1'b0;
        step();
        step();
        reset = 1'b0;

        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_level", bus.level, 0);
        chk("rst_result", bus.out_result, 16'h0000);
        chk("rst_sticky", bus.sticky_overflow, 0);
        chk("rst_count", bus.overflow_count, 0);

        // 0x7FFF + 0x0001 overflow result
        drive(1'b1, 16'h8000, 1'b1, 1'b0, 1'b1);
        chk("no_passthrough", bus.out_valid, 0);
        step();
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        chk("ovf_valid", bus.out_valid, 1);
        chk("ovf_result", bus.out_result, 16'h8000);
        chk("ovf_negative", bus.out_negative, 1);
        chk("ovf_zero", bus.out_zero, 0);
        chk("ovf_overflow", bus.out_overflow, 1);
        chk("ovf_sub", bus.out_sub, 0);
        chk("ovf_sticky", bus.sticky_overflow, 1);
        chk("ovf_count", bus.overflow_count, 1);
        step();
        chk("ovf_drained", bus.out_valid, 0);
        chk("ovf_drained_result", bus.out_result, 16'h0000);

        // Fill to two entries with the consumer stalled; third push is dropped
        drive(1'b1, 16'h0002, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b1, 16'h0000, 1'b0, 1'b1, 1'b0);
        step();
        chk("full_level", bus.level, 2);
        chk("full_in_ready", bus.in_ready, 0);
        drive(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
        step();
        chk("drop_level", bus.level, 2);
        chk("stall_head", bus.out_result, 16'h0002);
        chk("stall_sub", bus.out_sub, 1);
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        step();
        chk("pop1_level", bus.level, 1);
        chk("pop1_result", bus.out_result, 16'h0000);
        chk("pop1_zero", bus.out_zero, 1);
        chk("pop1_sub", bus.out_sub, 1);
        step();
        chk("pop2_empty", bus.out_valid, 0);
        chk("pop2_count", bus.overflow_count, 1);

        // Full + pop + push request: only the pop happens
        drive(1'b1, 16'h0011, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 16'h0022, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 16'h0033, 1'b0, 1'b0, 1'b1);
        chk("full_head", bus.out_result, 16'h0011);
        step();
        chk("fullpop_level", bus.level, 1);
        chk("fullpop_head", bus.out_result, 16'h0022);
        drive(1'b1, 16'h0044, 1'b0, 1'b0, 1'b1);
        step();
        chk("pushpop_level", bus.level, 1);
        chk("pushpop_head", bus.out_result, 16'h0044);
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        step();
        chk("pushpop_empty", bus.level, 0);

        // Counter saturation: count is 1 here, 256 more overflowing pushes
        drive(1'b1, 16'h8000, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 256; i++) step();
        chk("sat_count", bus.overflow_count, 255);
        chk("sat_sticky", bus.sticky_overflow, 1);
        bus.clear_status = 1'b1;
        step();
        chk("clr_push_count", bus.overflow_count, 1);
        chk("clr_push_sticky", bus.sticky_overflow, 1);
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        step();
        bus.clear_status = 1'b0;
        chk("clr_count", bus.overflow_count, 0);
        chk("clr_sticky", bus.sticky_overflow, 0);

        // Reset mid-stream with a full queue
        drive(1'b1, 16'h7001, 1'b1, 1'b0, 1'b0);
        step();
        step();
        chk("pre_rst_level", bus.level, 2);
        reset = 1'b1;
        drive(1'b1, 16'h5555, 1'b1, 1'b0, 1'b1);
        bus.clear_status = 1'b0;
        step();
        reset = 1'b0;
        chk("mid_rst_level", bus.level, 0);
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_sticky", bus.sticky_overflow, 0);
        chk("mid_rst_count", bus.overflow_count, 0);
        chk("mid_rst_in_ready", bus.in_ready, 1);

        // Tick low: pushes are ignored for three edges
        tick = 1'b0;
        drive(1'b1, 16'h0abc, 1'b1, 1'b1, 1'b0);
        step();
        step();
        step();
        chk("tick_low_level", bus.level, 0);
        chk("tick_low_count", bus.overflow_count, 0);
        tick = 1'b1;
        step();
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        chk("tick_high_level", bus.level, 1);
        chk("tick_high_result", bus.out_result, 16'h0abc);
        chk("tick_high_count", bus.overflow_count, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
